// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// mem_access_sequencer : data-memory port sequencer for the memory stage
// Revision: 1.0
// ============================================================================
module mem_access_sequencer #(
   parameter int XLEN      = 32,
   parameter int TIMEOUT   = 16,
   parameter int CNT_WIDTH = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic [6:0]      opcode_in,
   input  logic [2:0]      funct3_in,
   input  logic [XLEN-1:0] addr_in,
   input  logic [XLEN-1:0] store_data_in,
   output logic            halt_out,
   output logic [XLEN-1:0] load_data_out,
   output logic            load_valid,
   output logic            misalign_err,
   output logic            timeout_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [2:0]           f3_q;
   logic [1:0]           off_q;
   logic                 store_q;

   logic            is_load;
   logic            is_store;
   logic            start;
   logic            legal;
   logic            misalign;
   logic            bad;
   logic            hit_timeout;
   logic [3:0]      be_nxt;
   logic [XLEN-1:0] wdata_nxt;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] ext_data;

   assign is_load     = (opcode_in == OP_LOAD);
   assign is_store    = (opcode_in == OP_STORE);
   assign start       = (state == S_IDLE) && op_valid && (is_load || is_store);
   assign hit_timeout = (cnt == CNT_WIDTH'(TIMEOUT - 1));

   always_comb begin
      legal = 1'b0;
      case (funct3_in)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = is_load;
         default:                legal = 1'b0;
      endcase
   end

   assign misalign = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                     ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
   assign bad      = !legal || misalign;

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = store_data_in;
      case (funct3_in[1:0])
         2'b00: begin
            be_nxt    = 4'b0001 << addr_in[1:0];
            wdata_nxt = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            be_nxt    = 4'b0011 << addr_in[1:0];
            wdata_nxt = {2{store_data_in[15:0]}};
         end
         default: begin
            be_nxt    = 4'b1111;
            wdata_nxt = store_data_in;
         end
      endcase
   end

   // Bring the addressed lane down to bit 0 before extension.
   assign shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      ext_data = shifted;
      case (f3_q)
         3'b000:  ext_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  ext_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  ext_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  ext_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: ext_data = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = bad ? S_DONE : S_ACCESS;
         S_ACCESS: if (mem_ack || hit_timeout) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      halt_out = 1'b0;
      case (state)
         S_IDLE:   halt_out = start;
         S_ACCESS: halt_out = 1'b1;
         default:  halt_out = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         f3_q          <= '0;
         off_q         <= '0;
         store_q       <= 1'b0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_be        <= '0;
         mem_wdata     <= '0;
         load_data_out <= '0;
         load_valid    <= 1'b0;
         misalign_err  <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         load_valid   <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  f3_q    <= funct3_in;
                  off_q   <= addr_in[1:0];
                  store_q <= is_store;
                  cnt     <= '0;
                  if (bad) begin
                     misalign_err <= 1'b1;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {addr_in[XLEN-1:2], 2'b00};
                     mem_be    <= be_nxt;
                     mem_wdata <= wdata_nxt;
                  end
               end
            end
            S_ACCESS: begin
               // Ack takes priority over an expiring counter.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!store_q) begin
                     load_data_out <= ext_data;
                     load_valid    <= 1'b1;
                  end
               end else if (hit_timeout) begin
                  mem_req     <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Controls the data-memory port for the memory access stage.
- Accepts one LOAD or STORE at a time from the pipeline and checks alignment.
- Drives a variable-latency memory req/ack handshake with byte-lane enables, then returns sign- or zero-extended load data.
- Holds halt_out high so upstream stages freeze until the access finishes, aborts, or is rejected.

Parameters:
XLEN, 32, data and address width (only 32 supported).
TIMEOUT, 16, maximum cycles in ACCESS without mem_ack before abort (min 2).
CNT_WIDTH, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
op_valid  in  1  memory-stage operation present
opcode_in  in  7  opcode; LOAD=7'b0000011, STORE=7'b0100011
funct3_in  in  3  access size and sign
addr_in  in  XLEN  effective byte address
store_data_in  in  XLEN  rs2 store data
halt_out  out  1  pipeline stall request
load_data_out  out  XLEN  extended load result
load_valid  out  1  one-cycle pulse, load_data_out valid
misalign_err  out  1  one-cycle pulse, misaligned or illegal-funct3 access
timeout_err  out  1  one-cycle pulse, memory did not ack
mem_req  out  1  memory request, held until ack or abort
mem_we  out  1  1 = write
mem_addr  out  XLEN  word address, {addr[31:2],2'b00}
mem_be  out  4  byte-lane enables
mem_wdata  out  XLEN  lane-replicated store data
mem_ack  in  1  memory accept/complete, single cycle
mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
Clock and reset:
- Single clock, clk.
- rst is synchronous and active-high. It forces state IDLE, counter 0, and all registered outputs 0.
- A reset asserted mid-access drops mem_req on the next edge. No error pulse is produced.

States: IDLE, ACCESS, DONE.

IDLE:
- Start condition: op_valid=1 and opcode_in is LOAD or STORE. Any other opcode is ignored and halt_out stays 0.
- halt_out is combinational and equals 1 when the start condition is true in IDLE.
- On start, latch funct3, addr[1:0] and the load/store flag.
- Legal funct3 values:
  - LOAD: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - STORE: 000 SB, 001 SH, 010 SW.
- Misaligned cases: any halfword access with addr[0]=1; any word access with addr[1:0]≠0.
- Illegal funct3 or misaligned address: go to DONE with misalign_err set. No mem_req is issued.
- Otherwise go to ACCESS. Register mem_req=1, mem_we=store, mem_addr, mem_be and mem_wdata. Set counter to 0.

mem_be:
- Byte: 4'b0001 << addr[1:0].
- Half: 4'b0011 << addr[1:0].
- Word: 4'b1111.

mem_wdata:
- Byte: {4{sd[7:0]}}.
- Half: {2{sd[15:0]}}.
- Word: sd.

ACCESS:
- halt_out=1. mem_req and the address, enable and data outputs stay stable.
- mem_ack=1:
  - Drop mem_req and go to DONE.
  - For loads, register load_data_out = extend(mem_rdata >> 8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
- No ack and counter==TIMEOUT-1: drop mem_req, set timeout_err, go to DONE.
- Otherwise the counter increments.
- If ack and timeout coincide, ack wins and no error is flagged.

DONE (one cycle):
- halt_out=0. The upstream pipeline advances on this edge.
- load_valid=1 only for a successful load.
- Error flags are high only in this cycle.
- op_valid and opcode_in are ignored here because they still carry the finished op. Next state is IDLE.

Other rules:
- mem_ack outside ACCESS is ignored.
- load_data_out holds its value until the next successful load.
- Latency:
  - Ack in the first ACCESS cycle: halt_out high for 2 cycles, load_valid in cycle 3.
  - Generally: 2 + ack-wait cycles.
  - Misaligned access: halt_out high for 1 cycle.

Test Plan:
- LW addr 0x100, mem_ack first ACCESS cycle, rdata 0xDEADBEEF -> mem_be=1111, mem_addr 0x100, halt 2 cycles, load_valid with 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000 -> mem_be=1000, load_data_out 0xFFFFFF80. The same access with LBU -> 0x00000080.
- SH addr 0x202, sd 0x1234ABCD, ack after 3 cycles -> mem_we=1, mem_be=1100, mem_wdata 0xABCDABCD, mem_req high 4 cycles, no load_valid.
- LW addr 0x101 -> misalign_err pulse, mem_req never asserted, halt 1 cycle. LOAD funct3=011 -> misalign_err likewise.
- SW with no ack (TIMEOUT=16) -> mem_req high 16 cycles, then timeout_err pulse. Repeat with ack on the 16th cycle -> completes, no error.
- rst asserted during ACCESS wait -> mem_req=0, halt_out=0 next cycle, no pulses. Then back-to-back loads with op_valid held -> second access starts the cycle after DONE and is not duplicated.
